alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
//   Shares one fourbitALU instance (internal, alu_pkg::alu_opcode_t ops ADD/SUB/MUL/AND/DEC)
//   between N_REQ requesters. Round-robin arbitration, operand capture, FSM-sequenced execute,
//   and a registered response with valid/ready backpressure. Sits between client blocks and the ALU.
// PARAMETERS
//   N_REQ  4  number of requesters, legal range 2..8
//   ID_W   $clog2(N_REQ)  width of requester ID (derived, not overridden)
// PORTS
//   clk          in   1        single clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req_valid    in   N_REQ    per-requester request valid
//   req_op       in   3*N_REQ  per-requester opcode, slice i = [3*i+:3], alu_opcode_t encoding
//   req_a        in   4*N_REQ  per-requester operand a, slice [4*i+:4]
//   req_b        in   4*N_REQ  per-requester operand b, slice [4*i+:4]
//   req_ready    out  N_REQ    one-hot grant; request i accepted when req_valid[i] & req_ready[i]
//   rsp_valid    out  1        response valid
//   rsp_ready    in   1        response consumer ready
//   rsp_id       out  ID_W     index of requester that owns the response
//   rsp_result   out  5        ALU result (5-bit, ALU width rules)
//   rsp_err      out  1        1 = illegal opcode (3'b101..3'b111), result forced 0
//   busy         out  1        1 whenever FSM is not IDLE
// BEHAVIOUR
//   Reset (rst_n low, async): FSM=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0,
//     rsp_result=0, rsp_err=0, busy=0, captured operands=0. Reset mid-operation drops the
//     in-flight op; no response is produced for it.
//   FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready is combinational one-hot: first i with req_valid[i]=1 searching
//     rr_ptr, rr_ptr+1, ... wrapping mod N_REQ; all zero if no valid. On the edge with a
//     grant: capture op/a/b/id, rr_ptr <= (granted id + 1) mod N_REQ, go EXEC.
//     No valid -> stay IDLE, rr_ptr unchanged.
//   EXEC: captured op/a/b drive the ALU; on edge register rsp_result = ALU result,
//     rsp_err = (op > 3'b100), rsp_id = captured id; rsp_valid <= 1; go RESP.
//     Illegal op: ALU op input held at ADD, rsp_result=0, rsp_err=1.
//   RESP: outputs held stable while rsp_valid=1 & rsp_ready=0. On rsp_valid & rsp_ready:
//     rsp_valid <= 0, go IDLE. req_ready=0 in EXEC and RESP.
//   Latency: grant edge -> rsp_valid high 2 cycles later; peak throughput 1 op / 3 cycles.
//   Width rules (ALU-defined, 5-bit): ADD a+b (0..30); SUB a-b mod 32 (10-3=7, 3-10=5'b11001);
//     MUL a*b mod 32 (10*3 -> 5'b11110); AND zero-extended; DEC a-1 mod 32 (0 -> 5'b11111).
//   Requesters must hold req_* stable until accepted; deasserting req_valid before grant
//     is legal and the request is simply not served.
//   Simultaneous requests: exactly one grant per IDLE cycle; every continuously-valid
//     requester is served within N_REQ grants (starvation-free).
// CONFIGURATION
//   ALU_STATS_EN defined: adds outputs stat_ops[15:0] (increments on each rsp handshake)
//     and stat_errs[15:0] (increments on handshake with rsp_err=1); both saturate at
//     16'hFFFF, reset to 0.
//   ALU_STATS_EN undefined: stat ports and counters absent; all other behaviour identical.
// TESTING
//   1. Reset then idle: no req_valid for 10 cycles -> req_ready=0, rsp_valid=0, busy=0.
//   2. Single req0 ADD a=4'b1010 b=4'b0011, rsp_ready=1 -> rsp 2 cycles after grant:
//      rsp_id=0, rsp_result=5'b01101, rsp_err=0; repeat SUB/MUL/AND/DEC -> 00111/11110/00010/01001.
//   3. All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each
//      rsp_id matches grant order.
//   4. req2 op=3'b110 a=5 b=5 -> rsp_err=1, rsp_result=0 (ALU_STATS_EN: stat_errs=1).
//   5. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0,
//      no new grant until handshake; next grant the cycle after.
//   6. Assert rst_n=0 during EXEC -> all outputs zero immediately, no response after release.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares a single 4-bit ALU (fourbitALU) between N_REQ requesters.
//   A round-robin arbiter grants one requester per IDLE cycle. The granted
//   opcode/operands are captured, executed for one cycle, and returned as a
//   registered response that is held until the consumer accepts it.
//
//   Optional feature: define ALU_STATS_EN to add saturating 16-bit counters
//   of completed responses (stat_ops) and of error responses (stat_errs).
//
// Ports
//   clk         in   1          clock, all state on rising edge
//   rst_n       in   1          asynchronous active-low reset
//   req_valid   in   N_REQ      per-requester request valid
//   req_op      in   3*N_REQ    per-requester opcode, slice [3*i+:3]
//   req_a       in   4*N_REQ    per-requester operand a, slice [4*i+:4]
//   req_b       in   4*N_REQ    per-requester operand b, slice [4*i+:4]
//   req_ready   out  N_REQ      one-hot grant (only ever set in IDLE)
//   rsp_valid   out  1          response valid
//   rsp_ready   in   1          response consumer ready
//   rsp_id      out  ID_W       requester that owns the response
//   rsp_result  out  5          ALU result
//   rsp_err     out  1          illegal opcode flag, result forced to 0
//   busy        out  1          FSM is not IDLE
//   stat_ops    out  16         (ALU_STATS_EN only) response handshakes
//   stat_errs   out  16         (ALU_STATS_EN only) error handshakes
// ---------------------------------------------------------------------------

package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_AND = 3'd3,
    ALU_DEC = 3'd4
  } alu_opcode_t;
endpackage

// Purely combinational 4-bit ALU with a 5-bit result. Subtraction,
// multiplication and decrement wrap modulo 32.
module fourbitALU (
  input  alu_pkg::alu_opcode_t i_op,
  input  logic [3:0]           i_a,
  input  logic [3:0]           i_b,
  output logic [4:0]           o_result
);
  logic [7:0] w_product;

  assign w_product = {4'b0000, i_a} * {4'b0000, i_b};

  always_comb begin
    o_result = 5'd0;
    case (i_op)
      alu_pkg::ALU_ADD: o_result = {1'b0, i_a} + {1'b0, i_b};
      alu_pkg::ALU_SUB: o_result = {1'b0, i_a} - {1'b0, i_b};
      alu_pkg::ALU_MUL: o_result = w_product[4:0];
      alu_pkg::ALU_AND: o_result = {1'b0, i_a & i_b};
      alu_pkg::ALU_DEC: o_result = {1'b0, i_a} - 5'd1;
      default:          o_result = 5'd0;
    endcase
  end
endmodule

module alu_rr_scheduler #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [3*N_REQ-1:0]   req_op,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [4:0]           rsp_result,
  output logic                 rsp_err,
  output logic                 busy
`ifdef ALU_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_errs
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_rrPtr;
  logic [2:0]      r_op;
  logic [3:0]      r_a;
  logic [3:0]      r_b;
  logic [ID_W-1:0] r_id;
  logic            r_rspValid;
  logic [ID_W-1:0] r_rspId;
  logic [4:0]      r_rspResult;
  logic            r_rspErr;

  logic [N_REQ-1:0]     w_grant;
  logic [ID_W-1:0]      w_grantId;
  logic [ID_W-1:0]      w_idx;
  logic [ID_W-1:0]      w_nextPtr;
  logic                 w_found;
  logic [2:0]           w_selOp;
  logic [3:0]           w_selA;
  logic [3:0]           w_selB;
  logic                 w_illegal;
  alu_pkg::alu_opcode_t w_aluOp;
  logic [4:0]           w_aluResult;
  logic                 w_rspFire;

  // Round-robin search starting at r_rrPtr. The first valid requester found
  // wins; its opcode/operands are muxed out here so the capture register
  // only needs the winner. Grants are suppressed outside IDLE.
  always_comb begin
    w_grant   = '0;
    w_grantId = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    w_selOp   = '0;
    w_selA    = '0;
    w_selB    = '0;
    if (r_state == S_IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = ID_W'((int'(r_rrPtr) + k) % N_REQ);
        if (!w_found && req_valid[w_idx]) begin
          w_found          = 1'b1;
          w_grantId        = w_idx;
          w_grant[w_idx]   = 1'b1;
          w_selOp          = req_op[3*w_idx +: 3];
          w_selA           = req_a[4*w_idx +: 4];
          w_selB           = req_b[4*w_idx +: 4];
        end
      end
    end
  end

  // Pointer moves to just past the winner so that it has lowest priority
  // next time, which bounds every waiting requester to N_REQ grants.
  assign w_nextPtr = (w_grantId == ID_W'(N_REQ - 1)) ? '0 : w_grantId + 1'b1;

  // Illegal opcodes never reach the ALU; it sees ADD and the result is
  // discarded in favour of zero.
  assign w_illegal = (r_op > 3'b100);
  assign w_aluOp   = w_illegal ? alu_pkg::ALU_ADD : alu_pkg::alu_opcode_t'(r_op);

  fourbitALU u_alu (
    .i_op     (w_aluOp),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_aluResult)
  );

  assign w_rspFire = r_rspValid & rsp_ready;

  // Main sequencer: IDLE captures a grant, EXEC registers the ALU output,
  // RESP holds the response until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rrPtr     <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rspValid  <= 1'b0;
      r_rspId     <= '0;
      r_rspResult <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op    <= w_selOp;
            r_a     <= w_selA;
            r_b     <= w_selB;
            r_id    <= w_grantId;
            r_rrPtr <= w_nextPtr;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rspResult <= w_illegal ? 5'd0 : w_aluResult;
          r_rspErr    <= w_illegal;
          r_rspId     <= r_id;
          r_rspValid  <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_rspFire) begin
            r_rspValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  logic [15:0] r_statOps;
  logic [15:0] r_statErrs;

  // Saturating handshake counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_statOps  <= '0;
      r_statErrs <= '0;
    end else if (w_rspFire) begin
      if (r_statOps != 16'hFFFF) begin
        r_statOps <= r_statOps + 16'd1;
      end
      if (r_rspErr && (r_statErrs != 16'hFFFF)) begin
        r_statErrs <= r_statErrs + 16'd1;
      end
    end
  end

  assign stat_ops  = r_statOps;
  assign stat_errs = r_statErrs;
`endif

  assign req_ready  = w_grant;
  assign rsp_valid  = r_rspValid;
  assign rsp_id     = r_rspId;
  assign rsp_result = r_rspResult;
  assign rsp_err    = r_rspErr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed self-checking bench for alu_rr_scheduler (N_REQ = 4).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_result;
  logic        rsp_err;
  logic        busy;
`ifdef ALU_STATS_EN
  logic [15:0] statOps;
  logic [15:0] statErrs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
`ifdef ALU_STATS_EN
    ,
    .stat_ops   (statOps),
    .stat_errs  (statErrs)
`endif
  );

  // Reset values, then ten idle cycles with nothing requested.
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got ready=%b valid=%b id=%0d res=%b err=%b busy=%b, expected all zero",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_cycle_%0d: got ready=%b valid=%b busy=%b, expected 0000/0/0",
                 i, req_ready, rsp_valid, busy);
      end
    end
  endtask

  // Requester 0 alone, a=10 b=3, every legal opcode in turn.
  task automatic test_single_ops();
    logic [2:0] opTab  [5];
    logic [4:0] expTab [5];
    opTab[0] = 3'd0; expTab[0] = 5'b01101;
    opTab[1] = 3'd1; expTab[1] = 5'b00111;
    opTab[2] = 3'd2; expTab[2] = 5'b11110;
    opTab[3] = 3'd3; expTab[3] = 5'b00010;
    opTab[4] = 3'd4; expTab[4] = 5'b01001;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid    = 4'b0001;
      req_op[2:0]  = opTab[i];
      req_a[3:0]   = 4'b1010;
      req_b[3:0]   = 4'b0011;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL single_grant_op%0d: got ready=%b, expected 0001", i, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL single_exec_op%0d: got busy=%b valid=%b ready=%b, expected 1/0/0000",
                 i, busy, rsp_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== expTab[i] || rsp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_rsp_op%0d: got valid=%b id=%0d res=%b err=%b, expected 1/0/%b/0",
                 i, rsp_valid, rsp_id, rsp_result, rsp_err, expTab[i]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_done_op%0d: got valid=%b busy=%b, expected 0/0", i, rsp_valid, busy);
      end
    end
  endtask

  // All four requesters valid from reset: grants 0,1,2,3,0. Requester i
  // performs ADD (i+2)+1 so each response result identifies its owner.
  task automatic test_round_robin();
    int waitCyc;
    int expId;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_op[3*i +: 3] = 3'd0;
      req_a[4*i +: 4]  = 4'(i + 2);
      req_b[4*i +: 4]  = 4'd1;
    end
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      expId   = g % 4;
      waitCyc = 0;
      while (req_ready === 4'b0000 && waitCyc < 8) begin
        @(negedge clk);
        waitCyc++;
      end
      checks++;
      if (req_ready !== 4'(1 << expId)) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: got ready=%b, expected %b", g, req_ready, 4'(1 << expId));
      end
      @(negedge clk);
      waitCyc = 0;
      while (rsp_valid !== 1'b1 && waitCyc < 8) begin
        @(negedge clk);
        waitCyc++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(expId) || rsp_result !== 5'(expId + 3)) begin
        errors++;
        $display("[TB] FAIL rr_rsp_%0d: got valid=%b id=%0d res=%0d, expected 1/%0d/%0d",
                 g, rsp_valid, rsp_id, rsp_result, expId, expId + 3);
      end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Illegal opcode 3'b110 from requester 2.
  task automatic test_illegal_op();
    req_valid     = 4'b0100;
    req_op[8:6]   = 3'b110;
    req_a[11:8]   = 4'd5;
    req_b[11:8]   = 4'd5;
    rsp_ready     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL illegal_grant: got ready=%b, expected 0100", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 5'd0 || rsp_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL illegal_rsp: got valid=%b err=%b res=%b id=%0d, expected 1/1/00000/2",
               rsp_valid, rsp_err, rsp_result, rsp_id);
    end
    @(negedge clk);
`ifdef ALU_STATS_EN
    checks++;
    if (statErrs !== 16'd1) begin
      errors++;
      $display("[TB] FAIL illegal_stat_errs: got %0d, expected 1", statErrs);
    end
`endif
  endtask

  // Response stalled for five cycles; requester 1 waits behind it.
  // Pointer is at 3 here, so requester 0 wins first.
  task automatic test_back_pressure();
    req_op[2:0]  = 3'd2;
    req_a[3:0]   = 4'd3;
    req_b[3:0]   = 4'd4;
    req_op[5:3]  = 3'd0;
    req_a[7:4]   = 4'd1;
    req_b[7:4]   = 4'd1;
    req_valid    = 4'b0011;
    rsp_ready    = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL bp_grant0: got ready=%b, expected 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0010;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_exec: got ready=%b busy=%b, expected 0000/1", req_ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 5'd12 || rsp_err !== 1'b0 ||
          req_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b id=%0d res=%0d err=%b ready=%b, expected 1/0/12/0/0000",
                 i, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b, expected 0/0010", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 5'd2) begin
      errors++;
      $display("[TB] FAIL bp_second_rsp: got valid=%b id=%0d res=%0d, expected 1/1/2",
               rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
  endtask

  // Reset asserted while requester 3's op is in EXEC.
  task automatic test_reset_mid_op();
    req_op[11:9]  = 3'd0;
    req_a[15:12]  = 4'd7;
    req_b[15:12]  = 4'd7;
    req_valid     = 4'b1000;
    rsp_ready     = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL midrst_grant: got ready=%b, expected 1000", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_exec: got busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL midrst_async: got ready=%b valid=%b id=%0d res=%b err=%b busy=%b, expected all zero",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_after_%0d: got valid=%b busy=%b, expected 0/0", i, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_round_robin();
    test_illegal_op();
    test_back_pressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
